// File: rtl/en2pulse.sv
// Strobe-to-pulse converter: each accepted one-cycle enable yields a HIGH_W-cycle pulse
// followed by at least GAP_W low cycles; extra strobes are queued up to PEND_MAX or dropped.
module en2pulse #(
    parameter int unsigned HIGH_W   = 4,
    parameter int unsigned GAP_W    = 2,
    parameter int unsigned PEND_MAX = 3,
    localparam int unsigned PendW   = (PEND_MAX == 0) ? 1 : $clog2(PEND_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic             out_o,
    output logic             busy_o,
    output logic [PendW-1:0] pend_o,
    output logic             ovf_o
);

    localparam int unsigned MaxW = (HIGH_W > GAP_W) ? HIGH_W : GAP_W;
    localparam int unsigned CntW = (MaxW < 2) ? 1 : $clog2(MaxW + 1);

    localparam logic [CntW-1:0]  HighLd  = CntW'(HIGH_W - 1);
    localparam logic [CntW-1:0]  GapLd   = CntW'(GAP_W - 1);
    localparam logic [PendW-1:0] PendMax = PendW'(PEND_MAX);

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic [PendW-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             gap_end;

    assign gap_end = (state_q == StGap) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        busy_d  = busy_q;
        pend_d  = pend_q;
        ovf_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en_i) begin
                    state_d = StHigh;
                    cnt_d   = HighLd;
                    out_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StHigh: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StGap;
                    cnt_d   = GapLd;
                    out_d   = 1'b0;
                end
            end
            StGap: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if ((pend_q != '0) || en_i) begin
                    state_d = StHigh;
                    cnt_d   = HighLd;
                    out_d   = 1'b1;
                end else begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                out_d   = 1'b0;
                busy_d  = 1'b0;
                pend_d  = '0;
            end
        endcase

        // At GAP-end one queued request is consumed, so a strobe there always fits.
        if (state_q != StIdle) begin
            if (gap_end) begin
                if (pend_q != '0 && !en_i) begin
                    pend_d = pend_q - 1'b1;
                end
            end else if (en_i) begin
                if (pend_q < PendMax) begin
                    pend_d = pend_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_o  = out_q;
    assign busy_o = busy_q;
    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;

`ifndef SYNTHESIS
    a_out_implies_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_q |-> busy_q);
    a_pend_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
        pend_q <= PendMax);
    a_pend_only_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (pend_q != '0) |-> busy_q);
`endif

endmodule

// File: tb/tb_en2pulse.sv
// Scoreboard bench for en2pulse: several parameter sets share one strobe stream; a schedule
// model of pulse start times predicts out/busy/pend/ovf after every edge.
module tb_en2pulse;

    localparam int NCfg = 4;

    typedef struct {
        logic o;
        logic b;
        int   p;
        logic v;
    } exp_t;

    // Parameter sets: {HIGH_W, GAP_W, PEND_MAX}
    function automatic int unsigned cfg(int g, int f);
        int unsigned r;
        r = 1;
        case (g)
            0: r = (f == 0) ? 4 : (f == 1) ? 2 : 3;
            1: r = (f == 0) ? 4 : (f == 1) ? 2 : 0;
            2: r = (f == 0) ? 1 : (f == 1) ? 1 : 1;
            default: r = (f == 0) ? 3 : (f == 1) ? 5 : 2;
        endcase
        return r;
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    initial forever #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCfg; g++) begin : gen_dut
        localparam int unsigned H  = cfg(g, 0);
        localparam int unsigned G  = cfg(g, 1);
        localparam int unsigned PM = cfg(g, 2);
        localparam int unsigned PW = (PM == 0) ? 1 : $clog2(PM + 1);
        localparam int P = int'(H + G);

        logic          out_w;
        logic          busy_w;
        logic [PW-1:0] pend_w;
        logic          ovf_w;

        en2pulse #(
            .HIGH_W  (H),
            .GAP_W   (G),
            .PEND_MAX(PM)
        ) u_dut (
            .clk_i (clk),
            .rst_ni(rst_n),
            .en_i  (en),
            .out_o (out_w),
            .busy_o(busy_w),
            .pend_o(pend_w),
            .ovf_o (ovf_w)
        );

        exp_t exp_q[$];
        int   starts[$];
        int   t_now;
        int   last_s;
        int   ahead;
        exp_t e;

        // Reference: accepted requests become scheduled pulse start times spaced by H+G.
        initial begin
            t_now  = 0;
            last_s = -1000;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    starts.delete();
                    last_s = -1000;
                end else begin
                    t_now++;
                    while (starts.size() > 0 && starts[0] + P <= t_now) begin
                        void'(starts.pop_front());
                    end
                    ahead = 0;
                    foreach (starts[i]) if (starts[i] > t_now) ahead++;
                    e.v = 1'b0;
                    if (en) begin
                        if (t_now >= last_s + P) begin
                            last_s = t_now;
                            starts.push_back(t_now);
                        end else if (ahead < int'(PM)) begin
                            last_s = last_s + P;
                            starts.push_back(last_s);
                            ahead++;
                        end else begin
                            e.v = 1'b1;
                        end
                    end
                    e.o = 1'b0;
                    e.b = 1'b0;
                    foreach (starts[i]) begin
                        if (starts[i] <= t_now && t_now < starts[i] + int'(H)) e.o = 1'b1;
                        if (starts[i] <= t_now && t_now < starts[i] + P) e.b = 1'b1;
                    end
                    e.p = ahead;
                    exp_q.push_back(e);
                end
            end
        end

        initial begin : monitor
            exp_t x;
            forever begin
                @(posedge clk);
                #1;
                if (rst_n && exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    check($sformatf("cfg%0d out t=%0d", g, t_now), 32'(out_w), 32'(x.o));
                    check($sformatf("cfg%0d busy t=%0d", g, t_now), 32'(busy_w), 32'(x.b));
                    check($sformatf("cfg%0d pend t=%0d", g, t_now), 32'(pend_w), x.p);
                    check($sformatf("cfg%0d ovf t=%0d", g, t_now), 32'(ovf_w), 32'(x.v));
                end
            end
        end

        initial begin : reset_check
            forever begin
                @(negedge rst_n);
                #1;
                check($sformatf("cfg%0d rst out", g), 32'(out_w), 0);
                check($sformatf("cfg%0d rst busy", g), 32'(busy_w), 0);
                check($sformatf("cfg%0d rst pend", g), 32'(pend_w), 0);
                check($sformatf("cfg%0d rst ovf", g), 32'(ovf_w), 0);
            end
        end
    end

    task automatic drive(logic e);
        @(negedge clk);
        en = e;
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0);
    endtask

    task automatic pulse_reset(logic en_after);
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en = en_after;
    endtask

    initial begin
        int dens;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        idle(5);
        drive(1'b1); idle(12);                              // isolated strobe
        repeat (3) drive(1'b1); idle(25);                   // three queued strobes
        repeat (10) drive(1'b1); idle(40);                  // saturation and drops
        drive(1'b1); idle(5); drive(1'b1); idle(15);        // en on GAP-end, pend=0
        repeat (4) drive(1'b1); idle(2); drive(1'b1);       // en on GAP-end, pend full
        idle(40);
        drive(1'b1); drive(1'b0); drive(1'b1); idle(15);    // two strobes 2 apart

        drive(1'b1); drive(1'b0); drive(1'b0);              // reset during HIGH
        pulse_reset(1'b1);
        idle(15);

        for (int seg = 0; seg < 20; seg++) begin
            case ($urandom_range(0, 3))
                0: dens = 5;
                1: dens = 20;
                2: dens = 50;
                default: dens = 90;
            endcase
            repeat (100) drive(($urandom_range(0, 99) < dens) ? 1'b1 : 1'b0);
            if (seg == 10) pulse_reset(1'b0);
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
